// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register-access controller.
//   WORD_W       : SPI word width
//   STATUS_MAGIC : upper byte of the status word returned outside read bursts
//   CMD_WR_BIT   : command-word bit selecting write (1) or read (0)
//   state_t      : controller FSM states
package spi_reg_pkg;
    localparam int         WORD_W       = 16;
    localparam logic [7:0] STATUS_MAGIC = 8'hA5;
    localparam int         CMD_WR_BIT   = 15;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    // Word shown to the master while it clocks in a command or write data.
    function automatic logic [WORD_W-1:0] status_word(input logic e);
        return {STATUS_MAGIC, 7'b0, e};
    endfunction
endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Word-level link between spi_slave and the register controller.
//   spi_done : spi_slave word-complete level
//   spi_dout : word received by spi_slave, valid while spi_done=1
//   spi_din  : word spi_slave loads for its next transmit
// master modport = spi_slave side, slave modport = register controller side.
interface spi_reg_ctrl_if;
    import spi_reg_pkg::*;

    logic              spi_done;
    logic [WORD_W-1:0] spi_dout;
    logic [WORD_W-1:0] spi_din;

    modport master (output spi_done, output spi_dout, input spi_din);
    modport slave  (input spi_done, input spi_dout, output spi_din);
endinterface

// File: rtl/spi_reg_bank.sv
// Control register array plus control/status read mux.
//   clk, rst : clock, async active-low reset
//   we/waddr/wdata : control-register write port (waddr < NCTRL when we=1)
//   raddr/rdata    : combinational read, ctrl below NCTRL, status above
//   status         : live status inputs
//   ctrl           : control register contents
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int                NCTRL    = 4,
    parameter int                NSTAT    = 4,
    parameter int                ADDR_W   = 3,
    parameter logic [WORD_W-1:0] CTRL_RST = 16'h0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic [WORD_W-1:0]            wdata,
    input  logic [ADDR_W-1:0]            raddr,
    input  logic [NSTAT-1:0][WORD_W-1:0] status,
    output logic [NCTRL-1:0][WORD_W-1:0] ctrl,
    output logic [WORD_W-1:0]            rdata
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCTRL; i++) ctrl[i] <= CTRL_RST;
        end else begin
            for (int i = 0; i < NCTRL; i++)
                if (we && int'(waddr) == i) ctrl[i] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NCTRL; i++)
            if (int'(raddr) == i) rdata = ctrl[i];
        for (int j = 0; j < NSTAT; j++)
            if (int'(raddr) == NCTRL + j) rdata = status[j];
    end
endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI register-access controller. Decodes a command word followed by a burst
// of data words within one chip-select frame; writes control registers or
// returns control/status registers through spi_din.
//   clk, rst  : clock (shared with spi_slave), async active-low reset
//   ss        : raw active-low chip select (synchronized here)
//   spi       : spi_slave word link (done/dout in, din out)
//   status_in : flattened status registers, reg k at [16k+15:16k]
//   ctrl_q    : flattened control registers, same packing
//   wr_stb    : one-cycle pulse per accepted control write, wr_addr its address
//   err       : sticky error (write to a status address), cleared by next command
// NCTRL + NSTAT must equal 2**ADDR_W.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int                NCTRL    = 4,
    parameter int                NSTAT    = 4,
    parameter int                ADDR_W   = 3,
    parameter logic [WORD_W-1:0] CTRL_RST = 16'h0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ss,
    spi_reg_ctrl_if.slave             spi,
    input  logic [WORD_W*NSTAT-1:0]   status_in,
    output logic [WORD_W*NCTRL-1:0]   ctrl_q,
    output logic                      wr_stb,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic                      err
);
    logic              ss_meta, ss_sync, done_d;
    state_t            state, state_n;
    logic              rw_q, rw_n;
    logic [ADDR_W-1:0] addr_q, addr_n, wr_addr_n;
    logic [WORD_W-1:0] din_q, din_n, rdata;
    logic              wr_stb_n, err_n, err_set, err_clr, word_ev, we;

    assign word_ev     = spi.spi_done & ~done_d;
    assign spi.spi_din = din_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_meta <= 1'b1;
            ss_sync <= 1'b1;
            done_d  <= 1'b0;
            state   <= IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= status_word(1'b0);
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            err     <= 1'b0;
        end else begin
            ss_meta <= ss;
            ss_sync <= ss_meta;
            done_d  <= spi.spi_done;
            state   <= state_n;
            rw_q    <= rw_n;
            addr_q  <= addr_n;
            din_q   <= din_n;
            wr_stb  <= wr_stb_n;
            wr_addr <= wr_addr_n;
            err     <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        rw_n      = rw_q;
        addr_n    = addr_q;
        wr_stb_n  = 1'b0;
        wr_addr_n = wr_addr;
        we        = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        din_n     = din_q;

        // Deselect wins over any word event in the same cycle.
        if (ss_sync) begin
            state_n = IDLE;
            addr_n  = '0;
        end else begin
            unique case (state)
                IDLE: state_n = CMD;
                CMD: if (word_ev) begin
                    rw_n    = spi.spi_dout[CMD_WR_BIT];
                    addr_n  = spi.spi_dout[ADDR_W-1:0];
                    err_clr = 1'b1;
                    state_n = DATA;
                end
                DATA: if (word_ev) begin
                    if (rw_q) begin
                        if (int'(addr_q) < NCTRL) begin
                            we        = 1'b1;
                            wr_stb_n  = 1'b1;
                            wr_addr_n = addr_q;
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                    addr_n = addr_q + 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end

        err_n = err_set | (err & ~err_clr);

        // Read bursts load the word at the post-event address so it is ready
        // one clk after each event; everything else shows the status word.
        if (state_n == DATA && !rw_n) begin
            if (word_ev) din_n = rdata;
        end else begin
            din_n = status_word(err_n);
        end
    end

    spi_reg_bank #(
        .NCTRL(NCTRL), .NSTAT(NSTAT), .ADDR_W(ADDR_W), .CTRL_RST(CTRL_RST)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (addr_q),
        .wdata  (spi.spi_dout),
        .raddr  (addr_n),
        .status (status_in),
        .ctrl   (ctrl_q),
        .rdata  (rdata)
    );
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed scenarios plus random frames
// checked against a frame-level register model.
module tb_spi_reg_ctrl;
    logic        clk = 1'b0;
    logic        rst, ss;
    logic [63:0] status_in;
    logic [63:0] ctrl_q;
    logic        wr_stb;
    logic [2:0]  wr_addr;
    logic        err;

    spi_reg_ctrl_if sif();

    spi_reg_ctrl #(.NCTRL(4), .NSTAT(4), .ADDR_W(3), .CTRL_RST(16'h0000)) dut (
        .clk(clk), .rst(rst), .ss(ss), .spi(sif),
        .status_in(status_in), .ctrl_q(ctrl_q),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] tx_q[$], rx_q[$], post_q[$], exp_rx_q[$];
    logic [2:0]  stb_q[$], exp_stb_q[$];
    logic [15:0] ctrl_m[4];
    logic        err_m;

    always @(negedge clk) if (wr_stb === 1'b1) stb_q.push_back(wr_addr);

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ctrl_flat();
        return {ctrl_m[3], ctrl_m[2], ctrl_m[1], ctrl_m[0]};
    endfunction

    function automatic logic [15:0] reg_val(input int a);
        return (a < 4) ? ctrl_m[a] : status_in[(a-4)*16 +: 16];
    endfunction

    // Frame-level model: what the master should receive for each word of
    // tx_q and which writes should be strobed.
    task automatic model_frame();
        bit rw;
        int a;
        exp_rx_q.delete();
        exp_stb_q.delete();
        for (int i = 0; i < tx_q.size(); i++) begin
            if (i == 0) begin
                exp_rx_q.push_back({8'hA5, 7'b0, err_m});
                rw    = tx_q[0][15];
                a     = int'(tx_q[0][2:0]);
                err_m = 1'b0;
            end else begin
                exp_rx_q.push_back(rw ? {8'hA5, 7'b0, err_m} : reg_val(a));
                if (rw) begin
                    if (a < 4) begin
                        ctrl_m[a] = tx_q[i];
                        exp_stb_q.push_back(3'(a));
                    end else begin
                        err_m = 1'b1;
                    end
                end
                a = (a + 1) % 8;
            end
        end
    endtask

    // Drives one complete frame of tx_q; records what the master would shift
    // in (rx_q) and spi_din one clk after each word event (post_q).
    task automatic do_frame(input int hold);
        rx_q.delete();
        post_q.delete();
        stb_q.delete();
        @(negedge clk) ss = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < tx_q.size(); i++) begin
            repeat (6) @(negedge clk);
            rx_q.push_back(sif.spi_din);
            sif.spi_dout = tx_q[i];
            sif.spi_done = 1'b1;
            @(negedge clk);
            post_q.push_back(sif.spi_din);
            repeat (hold - 1) @(negedge clk);
            sif.spi_done = 1'b0;
        end
        repeat (4) @(negedge clk);
        ss = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; ss = 1'b1; status_in = '0;
        sif.spi_done = 1'b0; sif.spi_dout = '0;
        repeat (5) @(negedge clk);
        total++; if (ctrl_q !== 64'h0) begin bad++; $display("FAIL rst_ctrl actual=%h required=0", ctrl_q); end
        total++; if (sif.spi_din !== 16'hA500) begin bad++; $display("FAIL rst_din actual=%h required=a500", sif.spi_din); end
        total++; if (wr_stb !== 1'b0) begin bad++; $display("FAIL rst_stb actual=%b required=0", wr_stb); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err actual=%b required=0", err); end
        total++; if (wr_addr !== 3'd0) begin bad++; $display("FAIL rst_waddr actual=%0d required=0", wr_addr); end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (ctrl_q !== 64'h0 || sif.spi_din !== 16'hA500 || wr_stb !== 1'b0 || err !== 1'b0) begin
                bad++;
                $display("FAIL rst_release cyc=%0d actual=%h/%h/%b/%b required=0/a500/0/0",
                         i, ctrl_q, sif.spi_din, wr_stb, err);
            end
        end
        for (int i = 0; i < 4; i++) ctrl_m[i] = 16'h0;
        err_m = 1'b0;
    endtask

    task automatic test_write();
        tx_q = '{16'h8002, 16'h1234};
        model_frame();
        do_frame(1);
        total++; if (stb_q.size() != 1) begin bad++; $display("FAIL wr_count actual=%0d required=1", stb_q.size()); end
        else begin
            total++; if (stb_q[0] !== 3'd2) begin bad++; $display("FAIL wr_addr actual=%0d required=2", stb_q[0]); end
        end
        total++; if (ctrl_q !== 64'h0000_1234_0000_0000) begin bad++; $display("FAIL wr_ctrl actual=%h required=0000123400000000", ctrl_q); end
    endtask

    task automatic test_read_wrap();
        logic [15:0] exp_rx[4];
        logic [15:0] exp_post[3];
        tx_q = '{16'h8001, 16'hBEEF};
        model_frame();
        do_frame(1);
        status_in = '0;
        status_in[63:48] = 16'hCAFE;
        tx_q = '{16'h0007, 16'h1111, 16'h2222, 16'h3333};
        model_frame();
        do_frame(2);
        exp_rx   = '{16'hA500, 16'hCAFE, 16'h0000, 16'hBEEF};
        exp_post = '{16'hCAFE, 16'h0000, 16'hBEEF};
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rx_q[i] !== exp_rx[i]) begin bad++; $display("FAIL rd_word%0d actual=%h required=%h", i, rx_q[i], exp_rx[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (post_q[i] !== exp_post[i]) begin bad++; $display("FAIL rd_1clk%0d actual=%h required=%h", i, post_q[i], exp_post[i]); end
        end
        total++; if (stb_q.size() != 0) begin bad++; $display("FAIL rd_nostb actual=%0d required=0", stb_q.size()); end
    endtask

    task automatic test_err();
        tx_q = '{16'h8005, 16'hFFFF};
        model_frame();
        do_frame(1);
        total++; if (stb_q.size() != 0) begin bad++; $display("FAIL err_nostb actual=%0d required=0", stb_q.size()); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set actual=%b required=1", err); end
        total++; if (sif.spi_din !== 16'hA501) begin bad++; $display("FAIL err_din actual=%h required=a501", sif.spi_din); end
        tx_q = '{16'h0000, 16'h0000};
        model_frame();
        do_frame(1);
        total++; if (rx_q[0] !== 16'hA501) begin bad++; $display("FAIL err_status actual=%h required=a501", rx_q[0]); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear actual=%b required=0", err); end
        model_frame();
        do_frame(1);
        total++; if (rx_q[0] !== 16'hA500) begin bad++; $display("FAIL err_status2 actual=%h required=a500", rx_q[0]); end
    endtask

    task automatic test_abort();
        stb_q.delete();
        @(negedge clk) ss = 1'b0;
        repeat (4) @(negedge clk);
        sif.spi_dout = 16'h8001; sif.spi_done = 1'b1;
        @(negedge clk) sif.spi_done = 1'b0;
        err_m = 1'b0;
        repeat (8) @(negedge clk);
        ss = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (sif.spi_din !== 16'hA500) begin bad++; $display("FAIL abort_din actual=%h required=a500", sif.spi_din); end
        sif.spi_dout = 16'hFFFF; sif.spi_done = 1'b1;
        @(negedge clk) sif.spi_done = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (stb_q.size() != 0) begin bad++; $display("FAIL abort_nostb actual=%0d required=0", stb_q.size()); end
        total++; if (ctrl_q !== ctrl_flat()) begin bad++; $display("FAIL abort_ctrl actual=%h required=%h", ctrl_q, ctrl_flat()); end
        tx_q = '{16'h8001, 16'h5A5A};
        model_frame();
        do_frame(1);
        total++; if (stb_q.size() != 1 || stb_q[0] !== 3'd1) begin bad++; $display("FAIL abort_retry actual=%0d required=1 strobe at addr 1", stb_q.size()); end
        total++; if (ctrl_q[31:16] !== 16'h5A5A) begin bad++; $display("FAIL abort_retry_reg actual=%h required=5a5a", ctrl_q[31:16]); end
    endtask

    task automatic test_long_done();
        tx_q = '{16'h8003, 16'h0F0F};
        model_frame();
        do_frame(10);
        total++; if (stb_q.size() != 1) begin bad++; $display("FAIL long_done_count actual=%0d required=1", stb_q.size()); end
        total++; if (ctrl_q[63:48] !== 16'h0F0F) begin bad++; $display("FAIL long_done_reg actual=%h required=0f0f", ctrl_q[63:48]); end
    endtask

    task automatic test_reset_mid();
        stb_q.delete();
        @(negedge clk) ss = 1'b0;
        repeat (4) @(negedge clk);
        sif.spi_dout = 16'h8000; sif.spi_done = 1'b1;
        @(negedge clk) sif.spi_done = 1'b0;
        repeat (6) @(negedge clk);
        sif.spi_dout = 16'h4444; sif.spi_done = 1'b1;
        @(negedge clk) sif.spi_done = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (ctrl_q[15:0] !== 16'h4444) begin bad++; $display("FAIL mid_prewrite actual=%h required=4444", ctrl_q[15:0]); end
        sif.spi_dout = 16'h8888; sif.spi_done = 1'b1;
        #2 rst = 1'b0;
        #1;
        total++;
        if (ctrl_q !== 64'h0 || sif.spi_din !== 16'hA500 || err !== 1'b0 || wr_stb !== 1'b0 || wr_addr !== 3'd0) begin
            bad++;
            $display("FAIL mid_reset actual=%h/%h/%b/%b/%0d required=0/a500/0/0/0",
                     ctrl_q, sif.spi_din, err, wr_stb, wr_addr);
        end
        @(negedge clk) sif.spi_done = 1'b0; ss = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        stb_q.delete();
        sif.spi_dout = 16'h9999; sif.spi_done = 1'b1;
        @(negedge clk) sif.spi_done = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (stb_q.size() != 0) begin bad++; $display("FAIL mid_nostb actual=%0d required=0", stb_q.size()); end
        total++; if (ctrl_q !== 64'h0) begin bad++; $display("FAIL mid_ctrl actual=%h required=0", ctrl_q); end
        for (int i = 0; i < 4; i++) ctrl_m[i] = 16'h0;
        err_m = 1'b0;
    endtask

    task automatic test_random();
        int n;
        for (int f = 0; f < 30; f++) begin
            status_in = {$urandom, $urandom};
            tx_q.delete();
            tx_q.push_back({1'($urandom), 12'($urandom), 3'($urandom)});
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) tx_q.push_back(16'($urandom));
            model_frame();
            do_frame($urandom_range(1, 4));
            for (int i = 0; i < tx_q.size(); i++) begin
                total++;
                if (rx_q[i] !== exp_rx_q[i]) begin bad++; $display("FAIL rnd_rx f=%0d w=%0d actual=%h required=%h", f, i, rx_q[i], exp_rx_q[i]); end
            end
            total++;
            if (stb_q != exp_stb_q) begin bad++; $display("FAIL rnd_stb f=%0d actual=%0d strobes required=%0d", f, stb_q.size(), exp_stb_q.size()); end
            total++; if (ctrl_q !== ctrl_flat()) begin bad++; $display("FAIL rnd_ctrl f=%0d actual=%h required=%h", f, ctrl_q, ctrl_flat()); end
            total++; if (err !== err_m) begin bad++; $display("FAIL rnd_err f=%0d actual=%b required=%b", f, err, err_m); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wrap();
        test_err();
        test_abort();
        test_long_done();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
Register-access controller for the 16-bit SPI slave word engine. It decodes a command word plus a burst of data words within one chip-select frame. It writes control registers, or returns control and status registers through the slave's parallel load word (din). It sits between spi_slave (din/dout/done) and the chip's control and status fabric.

Parameters:
NCTRL, 4, number of read/write control registers, addresses 0..NCTRL-1
NSTAT, 4, number of read-only status registers, addresses NCTRL..NCTRL+NSTAT-1
ADDR_W, 3, address width; NCTRL+NSTAT must equal 2**ADDR_W
CTRL_RST, 16'h0000, reset value of every control register

Ports:
clk  in  1  system clock, the same clock as spi_slave
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
ss  in  1  raw SPI chip-select, active-low; synchronized internally with 2 flip-flops
spi_done  in  1  spi_slave done; level may stay high for several cycles
spi_dout  in  16  word received by spi_slave; valid while spi_done=1
spi_din  out  16  word spi_slave loads for its next transmit
ctrl_q  out  16*NCTRL  flattened control registers; reg k sits at bits [16k+15:16k]
status_in  in  16*NSTAT  flattened status inputs; same packing; sampled at read time
wr_stb  out  1  one-cycle pulse, asserted on each accepted control-register write
wr_addr  out  ADDR_W  address of the current wr_stb; valid when wr_stb=1
err  out  1  sticky error flag

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ctrl_q=all CTRL_RST, spi_din=16'hA500, wr_stb=0, wr_addr=0, err=0, address counter=0.
- Word event = rising edge of spi_done (spi_done=1 and the registered previous spi_done=0). Exactly one event per word, however long done stays high.
- Frame protocol: word 0 is the command. cmd[15]=1 means write, 0 means read. cmd[ADDR_W-1:0] is the start address. cmd[14:ADDR_W] is ignored. Words 1..N are data. After each data word the address increments modulo 2**ADDR_W.
- FSM states: IDLE, CMD, DATA.
  - IDLE: enter CMD when synchronized ss=0.
  - CMD: on a word event, latch rw and addr, then go to DATA.
  - DATA: on each word event, process the word and increment addr.
  - Any state: synchronized ss=1 forces IDLE in the next cycle, clears the address counter and restores spi_din=16'hA500 | err.
  - When ss=1 and a word event occur in the same cycle, ss wins and the word is discarded.
- spi_din timing:
  - IDLE and CMD: spi_din = {8'hA5, 7'b0, err}, so the master reads status while it sends the command.
  - Read: spi_din = reg[addr] exactly 1 clk after the command event, and reg[addr+1] exactly 1 clk after each data event.
  - Write: spi_din holds {8'hA5, 7'b0, err} throughout DATA.
  - This 1-clk update meets the slave's reload on the next SCK falling edge, provided the SCK half-period is at least 4 clk. That is a system requirement, not checked by this block.
- Write word (DATA, rw=1):
  - addr < NCTRL: ctrl reg[addr] = spi_dout on the event cycle +1; wr_stb=1 and wr_addr=addr on that same cycle.
  - addr >= NCTRL: no write, no wr_stb, err set to 1.
- Read mux: addresses below NCTRL return ctrl_q; addresses >= NCTRL return status_in[addr-NCTRL], sampled in the load cycle.
- err clearing: err is cleared on the command-word event of the next frame, after the status byte carrying err=1 has been shifted out. If a new error occurs in the same cycle as a clear, set wins.
- Address wrap: 2**ADDR_W-1 increments to 0.
- Reset asserted mid-frame: everything returns to reset values immediately. After release, the FSM waits in IDLE until ss is seen low again, since a partial frame is never resumed.

Decomposition:
- Shared package spi_reg_pkg holds:
  - the state enum (IDLE, CMD, DATA);
  - STATUS_MAGIC = 8'hA5;
  - CMD_WR_BIT = 15;
  - the 16-bit word width constant.
- Natural sub-module spi_reg_bank holds the control register array, the write port, the control/status read mux and the ctrl_q flattening.
- The FSM, edge detect, ss synchronizer and err logic stay in spi_reg_ctrl.

Test Plan:
1. Hold rst=0 for 5 clk -> ctrl_q=all 16'h0000, spi_din=16'hA500, wr_stb=0, err=0; outputs stable through reset release.
2. Frame with cmd 16'h8002 then data 16'h1234 -> exactly one wr_stb with wr_addr=2; ctrl_q[47:32]=16'h1234; other registers unchanged.
3. Set ctrl reg1=16'hBEEF and status_in reg 7=16'hCAFE. Frame with cmd 16'h0007 then 3 dummy words -> master receives 16'hA500, 16'hCAFE, 16'h0000 (reg0), 16'hBEEF (address wraps).
4. Frame with cmd 16'h8005 then data 16'hFFFF -> no wr_stb, err=1. The next frame's first word returns 16'hA501 and err clears. The following frame returns 16'hA500.
5. Frame with cmd 16'h8001, then ss rises after 8 data bits -> no wr_stb, FSM back in IDLE. The next full write frame to addr 1 succeeds.
6. Hold spi_done high for 10 clk during a write data word -> exactly one wr_stb. Separately, assert rst mid-burst -> immediate reset values, and no write completes after release until a new frame.
